ds1302_burst_reader: RTL and testbench
======================================

Name: ds1302_burst_reader

Overview:
Upstream feeder for the clock display path. On each poll request it runs one DS1302 3-wire clock-burst read of seconds, minutes and hours. It generates SCLK/CE itself and drives the shared data line through separate out/oe/in signals; the top level owns the tristate pad. It presents decoded BCD time, with a one-cycle valid strobe, to the digit/display stage.

Parameters:
CLK_DIV, 10, clk cycles per SCLK half-period (>=2)
CE_SETUP, 4, clk cycles CE high with SCLK low before first SCLK pulse (>=1)
CE_HOLD, 4, clk cycles CE high with SCLK low after last pulse (>=1)
CE_RECOVER, 8, clk cycles CE low before the next transaction may start (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  poll request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until back in IDLE
valid  out  1  one-cycle strobe; time outputs updated this cycle
seconds  out  8  BCD seconds, bit7 always 0
minutes  out  8  BCD minutes, bit7 always 0
hours  out  6  BCD hours, 00-23 or 01-12
mode_12h  out  1  RTC hour register in 12h mode
pm  out  1  PM flag (12h mode only, else 0)
halted  out  1  clock-halt (CH) bit of seconds register
rtc_sclk  out  1  serial clock to DS1302
rtc_ce  out  1  chip enable to DS1302
rtc_data_out  out  1  value driven on data line when rtc_data_oe=1
rtc_data_oe  out  1  1 = master drives data line
rtc_data_in  in  1  data line as seen at pad

Behaviour:
- Reset (synchronous, any state): FSM->IDLE; rtc_sclk=0, rtc_ce=0, rtc_data_oe=0, rtc_data_out=0, busy=0, valid=0, all time outputs and flags=0. Reset mid-transaction aborts immediately with no valid strobe.
- States: IDLE -> SETUP -> CMD -> READ -> HOLD -> RECOVER -> IDLE.
- IDLE: start=1 at cycle t -> SETUP at t+1 with rtc_ce=1, busy=1. start in any other state is ignored, not queued.
- SETUP: CE_SETUP cycles, SCLK low. The first command bit is driven from the first SETUP cycle.
- Pulses: 32 SCLK pulses, each = CLK_DIV cycles low then CLK_DIV cycles high, pulses numbered 1..32.
- CMD (pulses 1-8): rtc_data_oe=1; command 0xBF (clock burst read) sent LSB first. Bit j is driven from the start of the low phase of pulse j+1 and held through its high phase.
- READ (pulses 9-32): rtc_data_oe drops to 0 at the start of the low phase of pulse 9. Data bit k (k=0..23) is sampled from rtc_data_in on the last clk cycle of the low phase of pulse 9+k, LSB first, into a 24-bit shift register: byte0 = seconds reg, byte1 = minutes reg, byte2 = hours reg.
- HOLD: after the high phase of pulse 32, SCLK=0 and CE stays high for CE_HOLD cycles. The first cycle of RECOVER has rtc_ce=0, valid=1, and the outputs load:
  - seconds = {0, byte0[6:0]}; halted = byte0[7]
  - minutes = {0, byte1[6:0]}
  - mode_12h = byte2[7]
  - if mode_12h: hours = {0, byte2[4:0]}, pm = byte2[5]
  - else: hours = byte2[5:0], pm = 0
- RECOVER: CE_RECOVER cycles, CE low, busy=1, then IDLE with busy=0. start held high gives back-to-back reads separated by exactly CE_RECOVER+1 CE-low cycles.
- Transaction length: start to valid = 1 + CE_SETUP + 64*CLK_DIV + CE_HOLD cycles.
- Outputs hold their last value between valid strobes. No BCD range checking; out-of-range codes pass through.
- SCLK never toggles while CE is low. rtc_data_out changes only while SCLK is low.

Decomposition:
- ds1302_pkg holds: state enum; CMD_CLK_BURST_RD=8'hBF; CMD_BITS=8; READ_BITS=24; byte-field bit positions (CH=7, MODE12=7, PM=5).
- One sub-module, ds1302_phase_gen: counts CLK_DIV and emits low_end/high_end ticks plus the SCLK level. It is enabled only in CMD/READ and cleared by rst.

Test Plan:
- Reset: hold rst 3 cycles mid-idle -> all outputs 0, rtc_ce=0, rtc_sclk=0, rtc_data_oe=0.
- Nominal read, CLK_DIV=2: slave model returns 0x59,0x34,0x23 -> bus monitor decodes command 0xBF LSB-first, counts exactly 32 SCLK rises. Then seconds=0x59, minutes=0x34, hours=0x23, mode_12h=0, pm=0, halted=0, with valid high exactly 1 cycle at 1+CE_SETUP+128+CE_HOLD cycles after start.
- CH and 12h decode: slave returns 0xD9,0x07,0xB1 -> seconds=0x59, halted=1, minutes=0x07, hours=0x11, mode_12h=1, pm=1.
- Handshake: pulse start again while busy -> ignored (one transaction only). Hold start high continuously -> back-to-back transactions with CE low for CE_RECOVER+1 cycles between them.
- Abort: assert rst during READ pulse 15 -> next cycle rtc_ce=0, rtc_sclk=0, busy=0, no valid. A fresh start then completes a correct read of 0x00,0x00,0x12.
- Bus hygiene: across any transaction, rtc_data_out and rtc_data_oe never change while rtc_sclk=1, and rtc_data_oe=0 throughout pulses 9-32.

Source files
------------

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 clock-burst reader: FSM states,
// command byte, frame sizes and register bit positions.
package ds1302_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_READ,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    // Clock burst read: 0xBE burst address with the read bit set
    localparam logic [7:0] CMD_CLK_BURST_RD = 8'hBF;

    localparam int CMD_BITS  = 8;
    localparam int READ_BITS = 24;

    // Bit positions inside the seconds and hours registers
    localparam int CH_BIT     = 7;
    localparam int MODE12_BIT = 7;
    localparam int PM_BIT     = 5;

    // Width of the generic cycle counter used for SETUP/HOLD/RECOVER
    localparam int WAIT_W = 16;

endpackage

// File: rtl/ds1302_phase_gen.sv
// SCLK phase generator: while enabled, produces CLK_DIV cycles low then
// CLK_DIV cycles high, with ticks on the last cycle of each phase.
module ds1302_phase_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic low_end,
    output logic high_end
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end   = (cnt == CNT_W'(CLK_DIV - 1));
    assign low_end  = en && !sclk && at_end;
    assign high_end = en && sclk && at_end;

    // Half-period counter and SCLK level; parked low whenever disabled
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (at_end) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ds1302_burst_reader.sv
// DS1302 3-wire clock-burst reader: on a poll request it sends the burst
// read command, shifts in seconds/minutes/hours and presents decoded BCD
// time with a one-cycle valid strobe.
module ds1302_burst_reader
    import ds1302_pkg::*;
#(
    parameter int CLK_DIV    = 10,
    parameter int CE_SETUP   = 4,
    parameter int CE_HOLD    = 4,
    parameter int CE_RECOVER = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       valid,
    output logic [7:0] seconds,
    output logic [7:0] minutes,
    output logic [5:0] hours,
    output logic       mode_12h,
    output logic       pm,
    output logic       halted,
    output logic       rtc_sclk,
    output logic       rtc_ce,
    output logic       rtc_data_out,
    output logic       rtc_data_oe,
    input  logic       rtc_data_in
);

    state_t                 state;
    logic [WAIT_W-1:0]      wait_cnt;
    logic [4:0]             pulse_cnt;
    logic [CMD_BITS-2:0]    cmd_sr;
    logic [READ_BITS-1:0]   shift_reg;
    logic                   phase_en;
    logic                   low_end;
    logic                   high_end;
    logic [7:0]             byte0;
    logic [7:0]             byte1;
    logic [7:0]             byte2;
    logic                   unused_bits;

    assign phase_en    = (state == ST_CMD) || (state == ST_READ);
    assign byte0       = shift_reg[7:0];
    assign byte1       = shift_reg[15:8];
    assign byte2       = shift_reg[23:16];
    // Hours bit 6 carries no information in either hour mode
    assign unused_bits = byte2[6];

    ds1302_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (phase_en),
        .sclk     (rtc_sclk),
        .low_end  (low_end),
        .high_end (high_end)
    );

    // Transaction sequencer: drives CE, the data line and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            pulse_cnt    <= '0;
            cmd_sr       <= '0;
            shift_reg    <= '0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            seconds      <= '0;
            minutes      <= '0;
            hours        <= '0;
            mode_12h     <= 1'b0;
            pm           <= 1'b0;
            halted       <= 1'b0;
            rtc_ce       <= 1'b0;
            rtc_data_out <= 1'b0;
            rtc_data_oe  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_SETUP;
                        busy         <= 1'b1;
                        rtc_ce       <= 1'b1;
                        rtc_data_oe  <= 1'b1;
                        rtc_data_out <= CMD_CLK_BURST_RD[0];
                        cmd_sr       <= CMD_CLK_BURST_RD[7:1];
                        wait_cnt     <= '0;
                    end
                end
                ST_SETUP: begin
                    if (wait_cnt == WAIT_W'(CE_SETUP - 1)) begin
                        state     <= ST_CMD;
                        pulse_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_CMD: begin
                    if (high_end) begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                        if (pulse_cnt == 5'(CMD_BITS - 1)) begin
                            state        <= ST_READ;
                            rtc_data_oe  <= 1'b0;
                            rtc_data_out <= 1'b0;
                        end else begin
                            rtc_data_out <= cmd_sr[0];
                            cmd_sr       <= {1'b0, cmd_sr[CMD_BITS-2:1]};
                        end
                    end
                end
                ST_READ: begin
                    if (low_end) begin
                        shift_reg <= {rtc_data_in, shift_reg[READ_BITS-1:1]};
                    end
                    if (high_end) begin
                        if (pulse_cnt == 5'(CMD_BITS + READ_BITS - 1)) begin
                            state    <= ST_HOLD;
                            wait_cnt <= '0;
                        end else begin
                            pulse_cnt <= pulse_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (wait_cnt == WAIT_W'(CE_HOLD - 1)) begin
                        state    <= ST_RECOVER;
                        wait_cnt <= '0;
                        rtc_ce   <= 1'b0;
                        valid    <= 1'b1;
                        seconds  <= {1'b0, byte0[6:0]};
                        halted   <= byte0[CH_BIT];
                        minutes  <= {1'b0, byte1[6:0]};
                        mode_12h <= byte2[MODE12_BIT];
                        if (byte2[MODE12_BIT]) begin
                            hours <= {1'b0, byte2[4:0]};
                            pm    <= byte2[PM_BIT];
                        end else begin
                            hours <= byte2[5:0];
                            pm    <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RECOVER: begin
                    if (wait_cnt == WAIT_W'(CE_RECOVER - 1)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ds1302_burst_reader.sv
// Directed testbench for ds1302_burst_reader with a behavioural DS1302
// slave and a bus monitor on the 3-wire interface.
module tb_ds1302_burst_reader;

    localparam int CLK_DIV    = 2;
    localparam int CE_SETUP   = 4;
    localparam int CE_HOLD    = 4;
    localparam int CE_RECOVER = 8;
    localparam int TXN_LEN    = 1 + CE_SETUP + 64 * CLK_DIV + CE_HOLD;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       valid;
    logic [7:0] seconds;
    logic [7:0] minutes;
    logic [5:0] hours;
    logic       mode_12h;
    logic       pm;
    logic       halted;
    logic       rtc_sclk;
    logic       rtc_ce;
    logic       rtc_data_out;
    logic       rtc_data_oe;
    logic       rtc_data_in;

    ds1302_burst_reader #(
        .CLK_DIV    (CLK_DIV),
        .CE_SETUP   (CE_SETUP),
        .CE_HOLD    (CE_HOLD),
        .CE_RECOVER (CE_RECOVER)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .valid        (valid),
        .seconds      (seconds),
        .minutes      (minutes),
        .hours        (hours),
        .mode_12h     (mode_12h),
        .pm           (pm),
        .halted       (halted),
        .rtc_sclk     (rtc_sclk),
        .rtc_ce       (rtc_ce),
        .rtc_data_out (rtc_data_out),
        .rtc_data_oe  (rtc_data_oe),
        .rtc_data_in  (rtc_data_in)
    );

    always #5 clk = ~clk;

    int err_count   = 0;
    int check_count = 0;

    // Slave and monitor state
    logic [23:0] slave_data = '0;
    logic [7:0]  cmd_cap    = '0;
    int          rise_cnt   = 0;
    int          fall_cnt   = 0;
    int          hyg_err    = 0;
    int          ce_low_run = 0;
    int          last_gap   = 0;
    int          ce_rises   = 0;
    int          valid_total = 0;
    bit          mon_en     = 1'b0;
    logic        prev_ce    = 1'b0;
    logic        prev_sclk  = 1'b0;
    logic        prev_dout  = 1'b0;
    logic        prev_oe    = 1'b0;

    // Slave presents read bit k once the falling edge ending pulse 8+k is seen
    assign rtc_data_in = (rtc_ce && fall_cnt >= 8 && fall_cnt < 32) ? slave_data[fall_cnt - 8] : 1'b0;

    // DS1302 slave behaviour plus bus hygiene and CE timing monitor
    always @(negedge clk) begin
        if (rtc_ce && !prev_ce) begin
            rise_cnt = 0;
            fall_cnt = 0;
        end
        if (rtc_ce) begin
            if (rtc_sclk && !prev_sclk) begin
                if (rise_cnt < 8) cmd_cap[rise_cnt] = rtc_data_out;
                rise_cnt++;
            end
            if (!rtc_sclk && prev_sclk) fall_cnt++;
        end
        if (mon_en) begin
            if (rtc_sclk && (rtc_data_out !== prev_dout || rtc_data_oe !== prev_oe)) hyg_err++;
            if (rtc_sclk && !rtc_ce) hyg_err++;
            if (rtc_ce && fall_cnt >= 8 && rtc_data_oe) hyg_err++;
            if (!rtc_ce) begin
                ce_low_run++;
            end else begin
                if (!prev_ce) begin
                    last_gap = ce_low_run;
                    ce_rises++;
                end
                ce_low_run = 0;
            end
            if (valid) valid_total++;
        end
        prev_ce   = rtc_ce;
        prev_sclk = rtc_sclk;
        prev_dout = rtc_data_out;
        prev_oe   = rtc_data_oe;
    end

    // Single comparison point: counts and reports every check
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    // One poll: start pulse, optional stray start while busy, wait for return to idle
    task automatic applyStimulus(input logic [23:0] data, input int extra_start_at,
                                 output int latency, output int valid_cnt);
        int  n;
        bit  done;
        slave_data = data;
        latency    = -1;
        valid_cnt  = 0;
        n          = 0;
        done       = 1'b0;
        start      = 1'b1;
        while (!done && n < 1000) begin
            stepCycle();
            n++;
            start = (n == extra_start_at);
            if (n == 1) checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
            if (valid) begin
                valid_cnt++;
                if (latency < 0) latency = n;
            end
            if (n > 1 && !busy) done = 1'b1;
        end
        start = 1'b0;
        if (!done) checkOutput("txn_timeout", 32'd1, 32'd0);
    endtask

    int lat;
    int vcnt;
    int base_rises;
    int base_valid;
    int n;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) stepCycle();
        checkOutput("init_ce",    {31'd0, rtc_ce},      32'd0);
        checkOutput("init_sclk",  {31'd0, rtc_sclk},    32'd0);
        checkOutput("init_oe",    {31'd0, rtc_data_oe}, 32'd0);
        checkOutput("init_busy",  {31'd0, busy},        32'd0);
        checkOutput("init_valid", {31'd0, valid},       32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (2) stepCycle();

        // Nominal 24h read
        applyStimulus(24'h23_34_59, 0, lat, vcnt);
        checkOutput("t1_latency", lat, TXN_LEN);
        checkOutput("t1_valid_cnt", vcnt, 32'd1);
        checkOutput("t1_cmd", {24'd0, cmd_cap}, 32'hBF);
        checkOutput("t1_rises", rise_cnt, 32'd32);
        checkOutput("t1_seconds", {24'd0, seconds}, 32'h59);
        checkOutput("t1_minutes", {24'd0, minutes}, 32'h34);
        checkOutput("t1_hours", {26'd0, hours}, 32'h23);
        checkOutput("t1_flags", {29'd0, mode_12h, pm, halted}, 32'd0);

        // Reset held mid-idle clears every output
        rst = 1'b1;
        repeat (3) stepCycle();
        rst = 1'b0;
        checkOutput("rst_seconds", {24'd0, seconds}, 32'd0);
        checkOutput("rst_minutes", {24'd0, minutes}, 32'd0);
        checkOutput("rst_hours", {26'd0, hours}, 32'd0);
        checkOutput("rst_pins", {27'd0, rtc_ce, rtc_sclk, rtc_data_oe, rtc_data_out, busy}, 32'd0);
        stepCycle();

        // Clock-halt and 12h PM decode
        applyStimulus(24'hB1_07_D9, 0, lat, vcnt);
        checkOutput("t2_seconds", {24'd0, seconds}, 32'h59);
        checkOutput("t2_minutes", {24'd0, minutes}, 32'h07);
        checkOutput("t2_hours", {26'd0, hours}, 32'h11);
        checkOutput("t2_flags", {29'd0, mode_12h, pm, halted}, 32'd7);

        // Stray start while busy is ignored
        base_rises = ce_rises;
        applyStimulus(24'h01_02_03, 50, lat, vcnt);
        repeat (20) stepCycle();
        checkOutput("hs_ce_rises", ce_rises - base_rises, 32'd1);
        checkOutput("hs_valid_cnt", vcnt, 32'd1);
        checkOutput("hs_latency", lat, TXN_LEN);
        checkOutput("hs_busy_idle", {31'd0, busy}, 32'd0);

        // Start held high: back-to-back reads
        base_valid = valid_total;
        slave_data = 24'h09_45_30;
        start = 1'b1;
        n = 0;
        while (valid_total < base_valid + 2 && n < 1000) begin
            stepCycle();
            n++;
        end
        start = 1'b0;
        while (busy && n < 1200) begin
            stepCycle();
            n++;
        end
        checkOutput("b2b_valids", valid_total - base_valid, 32'd2);
        checkOutput("b2b_ce_gap", last_gap, CE_RECOVER + 1);
        checkOutput("b2b_minutes", {24'd0, minutes}, 32'h45);
        repeat (3) stepCycle();

        // Abort during READ pulse 15
        base_valid = valid_total;
        slave_data = 24'h55_55_55;
        start = 1'b1;
        stepCycle();
        start = 1'b0;
        n = 0;
        while (!(rtc_ce && fall_cnt == 14 && !rtc_sclk) && n < 1000) begin
            stepCycle();
            n++;
        end
        checkOutput("abort_reached", {31'd0, rtc_ce}, 32'd1);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkOutput("abort_pins", {28'd0, rtc_ce, rtc_sclk, busy, valid}, 32'd0);
        checkOutput("abort_seconds", {24'd0, seconds}, 32'd0);
        repeat (150) stepCycle();
        checkOutput("abort_no_valid", valid_total - base_valid, 32'd0);

        applyStimulus(24'h12_00_00, 0, lat, vcnt);
        checkOutput("t3_latency", lat, TXN_LEN);
        checkOutput("t3_seconds", {24'd0, seconds}, 32'h00);
        checkOutput("t3_minutes", {24'd0, minutes}, 32'h00);
        checkOutput("t3_hours", {26'd0, hours}, 32'h12);
        checkOutput("t3_flags", {29'd0, mode_12h, pm, halted}, 32'd0);

        checkOutput("bus_hygiene", hyg_err, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
